immediate_unit_mc: RTL and testbench

- Multi-channel, mode-capable successor to the single-register immediate unit.
- Decodes immediate-class instructions from the instruction fetch path into NUM_CHANNELS independent D_WIDTH immediate registers.
- Each instruction selects a channel and one of four modes: shift-append, sign-extend load, zero-extend load or clear.
- Has a parametrised bubble pipeline of depth PIPE_DEPTH to match FU datapath latency. Uses the standard serial config chain for stall-group selection.

---
 rtl/immu_pkg.sv | 27 ++
 rtl/immu_channel.sv | 80 ++++++++
 rtl/immediate_unit_mc.sv | 152 +++++++++++++++
 tb/tb_immediate_unit_mc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immu_pkg.sv
// rtl/immu_pkg.sv - Shared mode encodings, field widths and elaboration helpers for the immediate unit.
package immu_pkg;

    localparam logic [1:0] IMMU_MODE_SHIFT = 2'b00;
    localparam logic [1:0] IMMU_MODE_LDSX  = 2'b01;
    localparam logic [1:0] IMMU_MODE_LDZX  = 2'b10;
    localparam logic [1:0] IMMU_MODE_CLR   = 2'b11;

    // Instruction layout, MSB first: [WE][SEL(SEL_W)][MODE][PAYLOAD].
    localparam int IMMU_WE_W   = 1;
    localparam int IMMU_MODE_W = 2;
    localparam int IMMU_HDR_W  = IMMU_WE_W + IMMU_MODE_W;

    function automatic int immu_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int immu_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/immu_channel.sv
// rtl/immu_channel.sv - One immediate register with shift/sign-load/zero-load/clear update.
// Optional valid flag under IMMU_VALID_FLAGS_EN.
module immu_channel
    import immu_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int P_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [1:0]         mode,
    input  logic [P_W-1:0]     payload,
    output logic [D_WIDTH-1:0] value
`ifdef IMMU_VALID_FLAGS_EN
    ,
    output logic               valid
`endif
);

    logic [D_WIDTH-1:0] value_q, value_d;
    logic [D_WIDTH-1:0] shift_val, sx_val, zx_val;

    // A payload as wide as the register leaves nothing to shift in or extend.
    generate
        if (P_W >= D_WIDTH) begin : g_wide
            assign shift_val = payload[D_WIDTH-1:0];
            assign sx_val    = payload[D_WIDTH-1:0];
            assign zx_val    = payload[D_WIDTH-1:0];
        end else begin : g_narrow
            assign shift_val = {value_q[D_WIDTH-P_W-1:0], payload};
            assign sx_val    = {{(D_WIDTH-P_W){payload[P_W-1]}}, payload};
            assign zx_val    = {{(D_WIDTH-P_W){1'b0}}, payload};
        end
    endgenerate

    always_comb begin
        value_d = value_q;
        if (wr_en) begin
            case (mode)
                IMMU_MODE_SHIFT: value_d = shift_val;
                IMMU_MODE_LDSX:  value_d = sx_val;
                IMMU_MODE_LDZX:  value_d = zx_val;
                default:         value_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

`ifdef IMMU_VALID_FLAGS_EN
    logic valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d = (mode != IMMU_MODE_CLR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;
`endif

endmodule

// File: rtl/immediate_unit_mc.sv
// rtl/immediate_unit_mc.sv - Multi-channel immediate unit: pipeline, config chain, stall select, decode.
// IMMU_VALID_FLAGS_EN adds the oChannelValid output.
module immediate_unit_mc
    import immu_pkg::*;
#(
    parameter int I_IMM_WIDTH      = 16,
    parameter int D_WIDTH          = 32,
    parameter int NUM_CHANNELS     = 4,
    parameter int PIPE_DEPTH       = 1,
    parameter int NUM_STALL_GROUPS = 1
) (
    input  logic                            iClk,
    input  logic                            iReset,
    input  logic [NUM_STALL_GROUPS-1:0]     iStall,
    input  logic                            iConfigEnable,
    input  logic                            iConfigDataIn,
    output logic                            oConfigDataOut,
    input  logic [I_IMM_WIDTH-1:0]          iInstruction,
    output logic [NUM_CHANNELS*D_WIDTH-1:0] oImmediateOut
`ifdef IMMU_VALID_FLAGS_EN
    ,
    output logic [NUM_CHANNELS-1:0]         oChannelValid
`endif
);

    localparam int SEL_W        = immu_max(immu_clog2(NUM_CHANNELS), 1);
    localparam int P_W          = I_IMM_WIDTH - IMMU_HDR_W - SEL_W;
    localparam int SG_W         = immu_max(immu_clog2(NUM_STALL_GROUPS), 1);
    localparam int CONFIG_WIDTH = SG_W;
    localparam int SG_SPAN      = 1 << SG_W;
    localparam int WE_BIT       = I_IMM_WIDTH - 1;
    localparam int SEL_LSB      = WE_BIT - SEL_W;
    localparam int MODE_LSB     = P_W;
    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CHANNELS);

    generate
        if (P_W < 1 || NUM_CHANNELS < 1 || PIPE_DEPTH < 0 || PIPE_DEPTH > 4) begin : g_param_check
            $error("immediate_unit_mc: illegal parameters (payload width must be >=1, channels >=1, depth 0..4)");
        end
    endgenerate

    // Config chain is deliberately outside reset so it can be loaded while the unit is held.
    logic [CONFIG_WIDTH-1:0] config_q, config_d;

    always_comb begin
        config_d = config_q;
        if (iConfigEnable) begin
            for (int i = 0; i < CONFIG_WIDTH - 1; i++) begin
                config_d[i] = config_q[i+1];
            end
            config_d[CONFIG_WIDTH-1] = iConfigDataIn;
        end
    end

    always_ff @(posedge iClk) begin
        config_q <= config_d;
    end

    assign oConfigDataOut = config_q[0];

    // Unused group codes read the zero padding, so an out-of-range group never stalls.
    logic [SG_SPAN-1:0] stall_pad;
    logic               stall_q, stall_d;

    always_comb begin
        stall_pad = '0;
        stall_pad[NUM_STALL_GROUPS-1:0] = iStall;
        stall_d = stall_pad[config_q];
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    logic [I_IMM_WIDTH-1:0] dec_word;

    generate
        if (PIPE_DEPTH == 0) begin : g_nopipe
            assign dec_word = iInstruction;
        end else begin : g_pipe
            logic [I_IMM_WIDTH-1:0] pipe_q [PIPE_DEPTH];
            logic [I_IMM_WIDTH-1:0] pipe_d [PIPE_DEPTH];

            always_comb begin
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    pipe_d[i] = pipe_q[i];
                end
                if (!stall_q) begin
                    pipe_d[0] = iInstruction;
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                end
            end

            always_ff @(posedge iClk) begin
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    if (iReset) begin
                        pipe_q[i] <= '0;
                    end else begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign dec_word = pipe_q[PIPE_DEPTH-1];
        end
    endgenerate

    logic             dec_we, dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic [1:0]       dec_mode;
    logic [P_W-1:0]   dec_payload;

    assign dec_we      = dec_word[WE_BIT];
    assign dec_sel     = dec_word[SEL_LSB +: SEL_W];
    assign dec_mode    = dec_word[MODE_LSB +: IMMU_MODE_W];
    assign dec_payload = dec_word[P_W-1:0];
    assign dec_hit     = dec_we && !stall_q && ({1'b0, dec_sel} < NUM_CH_L);

    generate
        for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
            logic               ch_wr;
            logic [D_WIDTH-1:0] ch_value;

            assign ch_wr = dec_hit && (dec_sel == SEL_W'(k));

            immu_channel #(
                .D_WIDTH (D_WIDTH),
                .P_W     (P_W)
            ) u_channel (
                .clk     (iClk),
                .reset   (iReset),
                .wr_en   (ch_wr),
                .mode    (dec_mode),
                .payload (dec_payload),
                .value   (ch_value)
`ifdef IMMU_VALID_FLAGS_EN
                ,
                .valid   (oChannelValid[k])
`endif
            );

            assign oImmediateOut[k*D_WIDTH +: D_WIDTH] = ch_value;
        end
    endgenerate

endmodule

// File: tb/tb_immediate_unit_mc.sv
// tb/tb_immediate_unit_mc.sv - Scoreboard bench: 3-channel depth-2 two-group unit beside a 4-channel depth-0 unit.
module tb_immediate_unit_mc;

    logic         iClk = 1'b0;
    logic         iReset;
    logic [1:0]   iStall;
    logic         iConfigEnable;
    logic         iConfigDataIn;
    logic [15:0]  iInstruction;
    logic         cfg_out_a, cfg_out_b;
    logic [95:0]  imm_a;
    logic [127:0] imm_b;
`ifdef IMMU_VALID_FLAGS_EN
    logic [2:0]   valid_a;
    logic [3:0]   valid_b;
`endif

    always #5 iClk = ~iClk;

    immediate_unit_mc #(
        .I_IMM_WIDTH      (16),
        .D_WIDTH          (32),
        .NUM_CHANNELS     (3),
        .PIPE_DEPTH       (2),
        .NUM_STALL_GROUPS (2)
    ) dut_a (
        .iClk           (iClk),
        .iReset         (iReset),
        .iStall         (iStall),
        .iConfigEnable  (iConfigEnable),
        .iConfigDataIn  (iConfigDataIn),
        .oConfigDataOut (cfg_out_a),
        .iInstruction   (iInstruction),
        .oImmediateOut  (imm_a)
`ifdef IMMU_VALID_FLAGS_EN
        ,
        .oChannelValid  (valid_a)
`endif
    );

    immediate_unit_mc #(
        .I_IMM_WIDTH      (16),
        .D_WIDTH          (32),
        .NUM_CHANNELS     (4),
        .PIPE_DEPTH       (0),
        .NUM_STALL_GROUPS (1)
    ) dut_b (
        .iClk           (iClk),
        .iReset         (iReset),
        .iStall         (iStall[0]),
        .iConfigEnable  (iConfigEnable),
        .iConfigDataIn  (iConfigDataIn),
        .oConfigDataOut (cfg_out_b),
        .iInstruction   (iInstruction),
        .oImmediateOut  (imm_b)
`ifdef IMMU_VALID_FLAGS_EN
        ,
        .oChannelValid  (valid_b)
`endif
    );

    typedef struct {
        int           due;
        logic [127:0] v;
        logic [3:0]   f;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] ma [4];
    logic [31:0] mb [4];
    logic [3:0]  fa, fb;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic logic [31:0] apply_mode(input logic [31:0] old, input logic [1:0] m, input logic [10:0] p);
        case (m)
            2'b00:   return (old << 11) | {21'b0, p};
            2'b01:   return {{21{p[10]}}, p};
            2'b10:   return {21'b0, p};
            default: return 32'h0;
        endcase
    endfunction

    // Drive one instruction for the coming edge and push both units' expected snapshots.
    task automatic drive_instr(input logic [1:0] sel, input logic [1:0] mode, input logic [10:0] pay, input int extra_a);
        exp_t ea, eb;
        iInstruction = {1'b1, sel, mode, pay};
        if (sel < 2'd3) begin
            ma[sel] = apply_mode(ma[sel], mode, pay);
            fa[sel] = (mode != 2'b11);
        end
        mb[sel] = apply_mode(mb[sel], mode, pay);
        fb[sel] = (mode != 2'b11);
        ea.due = cyc + 3 + extra_a;
        ea.v   = {32'h0, ma[2], ma[1], ma[0]};
        ea.f   = {1'b0, fa[2:0]};
        eb.due = cyc + 1;
        eb.v   = {mb[3], mb[2], mb[1], mb[0]};
        eb.f   = fb;
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    // Advance to the next falling edge and retire every scoreboard entry that has come due.
    task automatic sb_step();
        exp_t e;
        @(negedge iClk);
        while (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            checks++;
            if (e.due != cyc || imm_a !== e.v[95:0]) begin
                failures++;
                $display("FAIL sb_a due=%0d cyc=%0d got=%h exp=%h", e.due, cyc, imm_a, e.v[95:0]);
            end
`ifdef IMMU_VALID_FLAGS_EN
            checks++;
            if (valid_a !== e.f[2:0]) begin
                failures++;
                $display("FAIL sb_a_flags cyc=%0d got=%b exp=%b", cyc, valid_a, e.f[2:0]);
            end
`endif
        end
        while (qb.size() > 0 && qb[0].due <= cyc) begin
            e = qb.pop_front();
            checks++;
            if (e.due != cyc || imm_b !== e.v) begin
                failures++;
                $display("FAIL sb_b due=%0d cyc=%0d got=%h exp=%h", e.due, cyc, imm_b, e.v);
            end
`ifdef IMMU_VALID_FLAGS_EN
            checks++;
            if (valid_b !== e.f) begin
                failures++;
                $display("FAIL sb_b_flags cyc=%0d got=%b exp=%b", cyc, valid_b, e.f);
            end
`endif
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && (qa.size() > 0 || qb.size() > 0); k++) begin
            sb_step();
        end
    endtask

    task automatic test_reset();
        iReset = 1'b1; iConfigEnable = 1'b1; iConfigDataIn = 1'b0;
        sb_step();
        checks++;
        if (cfg_out_a !== 1'b0 || cfg_out_b !== 1'b0) begin
            failures++;
            $display("FAIL cfg_shift0 got=%b/%b exp=0", cfg_out_a, cfg_out_b);
        end
        iConfigDataIn = 1'b1;
        sb_step();
        checks++;
        if (cfg_out_a !== 1'b1 || cfg_out_b !== 1'b1) begin
            failures++;
            $display("FAIL cfg_shift1 got=%b/%b exp=1", cfg_out_a, cfg_out_b);
        end
        iConfigEnable = 1'b0; iConfigDataIn = 1'b0; iReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_step();
            checks++;
            if (imm_a !== '0 || imm_b !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h/%h exp=0", cyc, imm_a, imm_b);
            end
        end
    endtask

    task automatic test_shift_seq();
        sb_step(); drive_instr(2'd2, 2'b10, 11'h001, 0);
        sb_step(); drive_instr(2'd2, 2'b00, 11'h002, 0);
        sb_step(); drive_instr(2'd2, 2'b00, 11'h003, 0);
        sb_step(); iInstruction = '0;
        drain();
        checks++;
        if (imm_a[95:64] !== 32'h0040_1003 || imm_b[95:64] !== 32'h0040_1003) begin
            failures++;
            $display("FAIL shift_seq_ch2 got=%h/%h exp=00401003", imm_a[95:64], imm_b[95:64]);
        end
    endtask

    task automatic test_sx_clear();
        sb_step(); drive_instr(2'd1, 2'b01, 11'h400, 0);
        sb_step(); drive_instr(2'd0, 2'b01, 11'h3FF, 0);
        sb_step(); iInstruction = '0;
        drain();
        checks++;
        if (imm_a[63:32] !== 32'hFFFF_FC00) begin
            failures++;
            $display("FAIL ldsx_neg got=%h exp=fffffc00", imm_a[63:32]);
        end
        sb_step(); drive_instr(2'd1, 2'b11, 11'h7FF, 0);
        sb_step(); iInstruction = '0;
        drain();
        checks++;
        if (imm_a !== {ma[2], ma[1], ma[0]} || imm_a[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL clear_ch1 got=%h exp_ch1=0", imm_a);
        end
    endtask

    task automatic test_stall();
        logic [31:0] prev;
        sb_step();
        prev = ma[0];
        iStall = 2'b10;
        drive_instr(2'd0, 2'b10, 11'h055, 3);
        sb_step(); iInstruction = '0;
        sb_step();
        sb_step(); iStall = 2'b00;
        sb_step();
        sb_step();
        checks++;
        if (imm_a[31:0] !== prev) begin
            failures++;
            $display("FAIL stall_hold got=%h exp=%h", imm_a[31:0], prev);
        end
        drain();
        // Group 1 is selected, so toggling group 0 must not disturb either unit.
        for (int i = 0; i < 4; i++) begin
            sb_step();
            iStall = (i % 2 == 0) ? 2'b01 : 2'b00;
            drive_instr(2'd0, 2'b00, 11'(17 * (i + 1)), 0);
        end
        sb_step(); iInstruction = '0; iStall = 2'b00;
        drain();
    endtask

    task automatic test_latency();
        logic [31:0] prev;
        sb_step();
        prev = ma[0];
        drive_instr(2'd0, 2'b10, 11'h123, 0);
        for (int i = 0; i < 2; i++) begin
            sb_step(); iInstruction = '0;
            checks++;
            if (imm_a[31:0] !== prev) begin
                failures++;
                $display("FAIL latency_early edge=%0d got=%h exp=%h", i + 1, imm_a[31:0], prev);
            end
        end
        drain();
    endtask

    task automatic test_out_of_range();
        sb_step(); drive_instr(2'd3, 2'b10, 11'h7FF, 0);
        sb_step(); drive_instr(2'd2, 2'b01, 11'h5A5, 0);
        sb_step(); iInstruction = '0;
        drain();
        checks++;
        if (imm_b[127:96] !== 32'h0000_07FF) begin
            failures++;
            $display("FAIL sel3_b got=%h exp=000007ff", imm_b[127:96]);
        end
    endtask

    task automatic test_mid_reset();
        sb_step();
        iInstruction = {1'b1, 2'd2, 2'b10, 11'h155};
        sb_step();
        iInstruction = '0;
        checks++;
        if (imm_b[95:64] !== 32'h0000_0155) begin
            failures++;
            $display("FAIL midreset_pre got=%h exp=00000155", imm_b[95:64]);
        end
        iReset = 1'b1;
        sb_step();
        iReset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imm_a !== '0 || imm_b !== '0) begin
                failures++;
                $display("FAIL midreset_zero step=%0d got=%h/%h exp=0", i, imm_a, imm_b);
            end
`ifdef IMMU_VALID_FLAGS_EN
            checks++;
            if (valid_a !== 3'b0 || valid_b !== 4'b0) begin
                failures++;
                $display("FAIL midreset_flags got=%b/%b exp=0", valid_a, valid_b);
            end
`endif
            sb_step();
        end
        for (int k = 0; k < 4; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
        fa = '0; fb = '0;
    endtask

    initial begin
        iReset = 1'b1; iStall = 2'b00; iConfigEnable = 1'b0; iConfigDataIn = 1'b0;
        iInstruction = '0;
        for (int k = 0; k < 4; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end
        fa = '0; fb = '0;
        test_reset();
        test_shift_seq();
        test_sx_clear();
        test_stall();
        test_latency();
        test_out_of_range();
        test_mid_reset();
        sb_step(); drive_instr(2'd1, 2'b10, 11'h00F, 0);
        sb_step(); iInstruction = '0;
        drain();
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
